priority_decoder_stream: RTL and testbench

// - Inverse of the leading-one priority encoder: expands a stream of 4-bit codes back into 10-bit vectors.
// - Code k (1..10): highest set bit is at index k-1. Code 0: all zero. Code 15: all ones. Codes 11..14 are illegal.
// - Sits on the unpacking side of the iteration-unit result path, between the code stream and the per-lane mask consumers.
// - Valid/ready on both sides, 2-entry output buffer, error flag and statistics counters.

---
 rtl/priority_decoder_stream_pkg.sv | 15 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/priority_decoder_stream.sv | 77 +++++++
 tb/tb_priority_decoder_stream.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_decoder_stream_pkg.sv
// Shared code-space definitions for the priority encoder/decoder pair.
package priority_decoder_stream_pkg;

  localparam int          PRIO_WIDTH    = 10;
  localparam logic [3:0]  CODE_ZERO     = 4'd0;
  localparam logic [3:0]  CODE_MAX      = 4'd10;
  localparam logic [3:0]  CODE_ALL_ONES = 4'hF;

  // A code is legal if it names a bit position inside the vector (0..width)
  // or is the all-ones escape code; everything in between is illegal.
  function automatic logic code_legal(input int code, input int width, input int code_w);
    return (code <= width) || (code == ((1 << code_w) - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: count-based full/empty, head shown on dout.
module sync_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Storage is never cleared, so mask the head while empty to hide stale data.
  assign dout  = empty ? '0 : mem[rptr];

  // Pointer and occupancy update; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; the caller guarantees no push when full.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/priority_decoder_stream.sv
// Expands a stream of leading-one codes back into WIDTH-bit vectors.
module priority_decoder_stream
  import priority_decoder_stream_pkg::*;
#(
  parameter int WIDTH      = PRIO_WIDTH,
  parameter int CODE_W     = 4,
  parameter int MODE       = 0,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  dec_count,
  output logic [CNT_W-1:0]  err_count
);
  logic             full, empty, accept, pop;
  logic [WIDTH-1:0] dec_data;
  logic             dec_err;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Decode the incoming code ahead of the buffer write.
  always_comb begin
    int k;
    k        = int'(in_code);
    dec_data = '0;
    dec_err  = 1'b0;
    if (!code_legal(k, WIDTH, CODE_W)) begin
      dec_err = 1'b1;
    end else if (k == ((1 << CODE_W) - 1)) begin
      dec_data = '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (MODE == 0) dec_data[i] = (i == k - 1);
        else           dec_data[i] = (i < k);
      end
    end
  end

  sync_fifo #(.DW(WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (pop),
    .din     ({dec_err, dec_data}),
    .dout    ({out_err, out_data}),
    .full    (full),
    .empty   (empty)
  );

  // Statistics: accepts wrap, illegal codes saturate, sticky flag latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_count  <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (accept) begin
      dec_count <= dec_count + 1'b1;
      if (dec_err) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_priority_decoder_stream.sv
// Self-checking bench: one-hot (narrow counters) and thermometer instances
// share stimulus; a scoreboard queue holds expected outputs for both.
module tb_priority_decoder_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] in_code;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_err0, sticky0;
  logic [9:0] out_data0;
  logic [3:0] dec_count0, err_count0;
  logic       in_ready1, out_valid1, out_err1, sticky1;
  logic [9:0] out_data1;
  logic [15:0] dec_count1, err_count1;

  always #5 clk = ~clk;

  priority_decoder_stream #(.MODE(0), .CNT_W(4)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_code(in_code), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_err(out_err0), .err_sticky(sticky0),
    .dec_count(dec_count0), .err_count(err_count0)
  );

  priority_decoder_stream #(.MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_code(in_code), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_err(out_err1), .err_sticky(sticky1),
    .dec_count(dec_count1), .err_count(err_count1)
  );

  typedef struct {
    logic [3:0] code;
    logic [9:0] d0;   // one-hot expectation
    logic [9:0] d1;   // thermometer expectation
    logic       err;
  } vec_t;

  typedef struct {
    logic [9:0] d0;
    logic [9:0] d1;
    logic       err;
  } exp_t;

  exp_t q[$];
  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: compare the FIFO head whenever it will be popped at the next edge.
  always @(negedge clk) begin
    if (mon_en && out_valid0 && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'(out_data0), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data_mode0", 32'(out_data0), 32'(e.d0));
        check("out_data_mode1", 32'(out_data1), 32'(e.d1));
        check("out_err",        32'({out_err0, out_err1}), 32'({e.err, e.err}));
      end
    end
  end

  // Offer one code and record its expectation on the cycle it is taken.
  task automatic send(input vec_t v);
    exp_t e;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_code  = v.code;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready0) begin
        e.d0 = v.d0; e.d1 = v.d1; e.err = v.err;
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && (q.size() != 0 || out_valid0); n++) begin
      @(posedge clk); #1;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    q.delete();
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic [9:0] held;
    vecs[0]  = '{4'd0,  10'h000, 10'h000, 1'b0};
    vecs[1]  = '{4'd1,  10'h001, 10'h001, 1'b0};
    vecs[2]  = '{4'd5,  10'h010, 10'h01F, 1'b0};
    vecs[3]  = '{4'd10, 10'h200, 10'h3FF, 1'b0};
    vecs[4]  = '{4'd15, 10'h3FF, 10'h3FF, 1'b0};
    vecs[5]  = '{4'd3,  10'h004, 10'h007, 1'b0};
    vecs[6]  = '{4'd12, 10'h000, 10'h000, 1'b1};
    vecs[7]  = '{4'd2,  10'h002, 10'h003, 1'b0};
    vecs[8]  = '{4'd7,  10'h040, 10'h07F, 1'b0};
    vecs[9]  = '{4'd11, 10'h000, 10'h000, 1'b1};
    vecs[10] = '{4'd14, 10'h000, 10'h000, 1'b1};
    vecs[11] = '{4'd9,  10'h100, 10'h1FF, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
    do_reset();
    check("rst_out_valid", 32'({out_valid0, out_valid1}), 32'd0);
    check("rst_out_data",  32'(out_data0), 32'd0);
    check("rst_out_err",   32'(out_err0), 32'd0);
    check("rst_sticky",    32'({sticky0, sticky1}), 32'd0);
    check("rst_counts",    32'({dec_count0, err_count0}), 32'd0);
    check("rst_in_ready",  32'(in_ready0), 32'd1);
    mon_en = 1'b1;

    // Legal codes back to back with the consumer always ready.
    for (int i = 0; i < 5; i++) send(vecs[i]);
    drain();
    check("dec_count_5",  32'(dec_count1), 32'd5);
    check("sticky_clean", 32'(sticky0), 32'd0);

    // Remaining table entries including illegal codes.
    for (int i = 5; i < 12; i++) begin
      send(vecs[i]);
      if (i == 6) check("sticky_after_12", 32'({sticky0, sticky1}), 32'b11);
      if (i == 6) check("err_count_1", 32'(err_count1), 32'd1);
    end
    drain();
    check("err_count_3", 32'(err_count1), 32'd3);
    check("dec_count_12", 32'(dec_count1), 32'd12);

    // One-cycle latency, no bypass into an empty FIFO.
    in_valid = 1'b1; in_code = vecs[2].code;
    @(negedge clk);
    check("no_bypass", 32'(out_valid0), 32'd0);
    check("lat_in_ready", 32'(in_ready0), 32'd1);
    q.push_back('{vecs[2].d0, vecs[2].d1, vecs[2].err});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("latency_1", 32'(out_valid0), 32'd1);
    drain();

    // Back-pressure: two codes fill the buffer, the third waits.
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[8]);
    in_valid = 1'b1; in_code = vecs[11].code;
    @(negedge clk);
    check("full_in_ready", 32'(in_ready0), 32'd0);
    held = out_data0;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_stable", 32'(out_data0), 32'(held));
    check("stall_valid", 32'(out_valid0), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_no_passthru", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    send(vecs[11]);
    drain();

    // Reset with two entries buffered discards them.
    out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    check("pre_rst_full", 32'(in_ready0), 32'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    check("midrst_valid",  32'({out_valid0, out_valid1}), 32'd0);
    check("midrst_counts", 32'({dec_count1, err_count1}), 32'd0);
    check("midrst_sticky", 32'(sticky1), 32'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_valid", 32'(out_valid0), 32'd0);
    check("post_rst_data",  32'(out_data0), 32'd0);

    // Counter wrap (4-bit) and error saturation.
    for (int i = 0; i < 19; i++) send(vecs[1]);
    drain();
    check("dec_wrap_4bit", 32'(dec_count0), 32'd3);
    check("dec_count_19",  32'(dec_count1), 32'd19);
    for (int i = 0; i < 20; i++) begin
      v = vecs[(i % 2 == 0) ? 6 : 10];
      send(v);
    end
    drain();
    check("err_sat_4bit",  32'(err_count0), 32'd15);
    check("err_count_20",  32'(err_count1), 32'd20);
    check("dec_after_err", 32'(dec_count0), 32'd7);
    check("sticky_set",    32'(sticky0), 32'd1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
